// File: rtl/lightsaber_blade_ignition.sv
// Blade ignition/retraction ramp: turns the 2-bit blade configuration into per-emitter
// lengths that walk one unit every STEP_DIV cycles toward their targets.
module lightsaber_blade_ignition #(
    parameter int LEN_W    = 4,
    parameter int MAX_LEN  = 15,
    parameter int HILT_LEN = 3,
    parameter int STEP_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       cfg,
    output logic [LEN_W-1:0] main_len,
    output logic [LEN_W-1:0] rear_len,
    output logic [LEN_W-1:0] hilt_len,
    output logic [1:0]       state,
    output logic             stable
);

    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_RAMPING = 2'd1,
        ST_STABLE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [LEN_W-1:0] main_q, main_d;
    logic [LEN_W-1:0] rear_q, rear_d;
    logic [LEN_W-1:0] hilt_q, hilt_d;

    logic [1:0]       cfg_eff;
    logic [LEN_W-1:0] main_tgt, rear_tgt, hilt_tgt;
    logic [LEN_W-1:0] main_step, rear_step, hilt_step;
    logic             any_tgt, match, step_match;

    // Compare before adjusting so an unsigned length can never wrap.
    function automatic logic [LEN_W-1:0] step_toward(input logic [LEN_W-1:0] cur,
                                                     input logic [LEN_W-1:0] tgt);
        if (cur < tgt) return cur + LEN_W'(1);
        if (cur > tgt) return cur - LEN_W'(1);
        return cur;
    endfunction

    assign cfg_eff  = en ? cfg : 2'd0;
    assign main_tgt = (cfg_eff != 2'd0) ? LEN_W'(MAX_LEN) : '0;
    assign rear_tgt = (cfg_eff[1])      ? LEN_W'(MAX_LEN) : '0;
    assign hilt_tgt = (cfg_eff == 2'd3) ? LEN_W'(HILT_LEN) : '0;
    assign any_tgt  = (cfg_eff != 2'd0);

    assign match = (main_q == main_tgt) && (rear_q == rear_tgt) && (hilt_q == hilt_tgt);

    assign main_step  = step_toward(main_q, main_tgt);
    assign rear_step  = step_toward(rear_q, rear_tgt);
    assign hilt_step  = step_toward(hilt_q, hilt_tgt);
    assign step_match = (main_step == main_tgt) && (rear_step == rear_tgt) &&
                        (hilt_step == hilt_tgt);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = '0;
        main_d    = main_q;
        rear_d    = rear_q;
        hilt_d    = hilt_q;
        unique case (state_q)
            ST_RAMPING: begin
                if (match) begin
                    state_d = any_tgt ? ST_STABLE : ST_OFF;
                end else if (div_cnt_q != DIV_LAST) begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end else begin
                    main_d = main_step;
                    rear_d = rear_step;
                    hilt_d = hilt_step;
                    if (step_match) state_d = any_tgt ? ST_STABLE : ST_OFF;
                end
            end
            default: begin
                if (!match) state_d = ST_RAMPING;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_OFF;
            div_cnt_q <= '0;
            main_q    <= '0;
            rear_q    <= '0;
            hilt_q    <= '0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            main_q    <= main_d;
            rear_q    <= rear_d;
            hilt_q    <= hilt_d;
        end
    end

    assign main_len = main_q;
    assign rear_len = rear_q;
    assign hilt_len = hilt_q;
    assign state    = state_q;
    assign stable   = (state_q == ST_STABLE);

endmodule

// File: doc/lightsaber_blade_ignition.md
Name: lightsaber_blade_ignition

Overview:
- Downstream consumer of the 2-bit blade configuration register output. Turns the selected configuration into per-emitter blade lengths that ramp up or down over time (ignition/retraction) instead of switching instantly.
- Drives the main emitter, the rear emitter and the hilt quillons (crossguard).
- Reports the ramp status to display/sound logic further downstream.

Parameters:
- LEN_W, 4, width of each length output.
- MAX_LEN, 15, full length of the main and rear blades; must be ≤ 2^LEN_W-1.
- HILT_LEN, 3, full length of the quillon blades; must be ≤ MAX_LEN.
- STEP_DIV, 4, clock cycles per one-unit length step; must be ≥1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous active-high reset.
- en  in  1  saber power; 0 forces all targets to 0.
- cfg  in  2  configuration from the config register: 0 off, 1 single, 2 double, 3 hilted.
- main_len  out  LEN_W  current main blade length.
- rear_len  out  LEN_W  current rear blade length.
- hilt_len  out  LEN_W  current quillon length.
- state  out  2  0 OFF, 1 RAMPING, 2 STABLE (3 unused, never produced).
- stable  out  1  high iff state==STABLE.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst is synchronous and active-high. While rst=1 at an edge: all lengths 0, state OFF, internal div_cnt 0, stable 0.
  - rst has priority over every other input.
- Targets (combinational from the current inputs; effective cfg = en ? cfg : 0):
  - main_tgt = MAX_LEN if cfg∈{1,2,3}, else 0.
  - rear_tgt = MAX_LEN if cfg∈{2,3}, else 0.
  - hilt_tgt = HILT_LEN if cfg==3, else 0.
- "match" means all three lengths equal their targets.
- State machine, per edge when not in reset:
  - OFF or STABLE, match: hold; div_cnt stays 0.
  - OFF or STABLE, !match: go to RAMPING with div_cnt←0; lengths unchanged on this edge.
  - RAMPING, match (targets moved onto the current lengths): go to STABLE if any target ≠0, else OFF; div_cnt←0.
  - RAMPING, !match, div_cnt<STEP_DIV-1: div_cnt++; lengths unchanged.
  - RAMPING, !match, div_cnt==STEP_DIV-1 ("step"): div_cnt←0. Each length moves exactly 1 toward its own target (+1 if below, -1 if above, hold if equal). If all lengths match after the step, the state goes to STABLE (any target ≠0) or OFF (all targets 0) on this same edge; otherwise it stays RAMPING.
- Lengths never jump by more than 1 per step and never overshoot their target.
- Different channels may finish at different steps.
- Target changes mid-ramp, including reversal, do not restart div_cnt; the next step simply moves toward the new target.
- Timing, from a target change seen at edge 0 while STABLE/OFF:
  - First length change at edge STEP_DIV+1.
  - A length reaches distance d at edge 1+d·STEP_DIV.
  - STEP_DIV=1 must work: a step occurs on every RAMPING edge.
- Arithmetic: unsigned LEN_W-bit lengths; compare before inc/dec so no wrap-around is possible.
- Outputs are registered, except `stable`, which is decoded directly from the state register.

Test Plan:
1. rst, then en=1 cfg=1 from edge 0 → state RAMPING at edge 1; main_len=1 at edge 5, 15 at edge 61 with state STABLE/stable=1 on that edge; rear_len=hilt_len=0 throughout.
2. From STABLE single, cfg=3 → rear_len ramps 0→15 by edge 61; hilt_len stops at 3 after edge 13 while rear continues; main_len stays 15; STABLE at edge 61.
3. From STABLE double, en=0 (cfg held 2) → main and rear decrement together, both 0 at edge 61; state OFF; hilt_len stays 0.
4. Off, cfg=1; when main_len reaches 6, set cfg=0 → next step main_len=5 (no jump, div_cnt not reset); reaches 0 → state OFF, stable=0.
5. rst=1 mid-ramp with main_len=8 → next edge all lengths 0, state OFF. Release with cfg=1 → full ramp timing from scratch: main_len=1 at edge 5 after release.
6. STEP_DIV=1, HILT_LEN=3, cfg=0→3 → hilt_len=3 at edge 4; main_len=rear_len=15 at edge 16, STABLE on that edge. cfg changed 3→3 (no change) → stays STABLE.
